// File: rtl/prbs_pkg.sv
// Shared types and polynomial tables for the PRBS pattern source.
//  state_t : controller states (IDLE, HEADER, PRBS)
//  poly_e  : polynomial select, encoded as on the poly_sel port
//  LEN_TBL / TAP_TBL : register length L and second tap T per polynomial
//  lfsr_len / lfsr_mask : helpers returning L and the L-bit active mask
package prbs_pkg;

   localparam int unsigned LFSR_W = 31;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HEADER = 2'd1,
      PRBS   = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      POLY7  = 2'd0,
      POLY15 = 2'd1,
      POLY23 = 2'd2,
      POLY31 = 2'd3
   } poly_e;

   // Element [0] is the right-most entry of each concatenation.
   localparam logic [3:0][4:0] LEN_TBL = {5'd31, 5'd23, 5'd15, 5'd7};
   localparam logic [3:0][4:0] TAP_TBL = {5'd28, 5'd18, 5'd14, 5'd6};

   function automatic logic [4:0] lfsr_len(input poly_e p);
      return LEN_TBL[p];
   endfunction

   function automatic logic [4:0] lfsr_tap(input poly_e p);
      return TAP_TBL[p];
   endfunction

   // Ones in the L active bit positions; upper bits stay zero.
   function automatic logic [LFSR_W-1:0] lfsr_mask(input poly_e p);
      return LFSR_W'((32'd1 << lfsr_len(p)) - 32'd1);
   endfunction

endpackage

// File: rtl/prbs_lfsr_step.sv
// Combinational LFSR advance of DATA_W steps.
//  state_in  : current 31-bit register (bits above L ignored)
//  poly      : polynomial select
//  state_out : register after DATA_W steps (bits above L zero)
//  bits_out  : feedback bits, first generated bit in the MSB
import prbs_pkg::*;

module prbs_lfsr_step #(
   parameter int unsigned DATA_W = 8
) (
   input  logic [LFSR_W-1:0] state_in,
   input  poly_e             poly,
   output logic [LFSR_W-1:0] state_out,
   output logic [DATA_W-1:0] bits_out
);

   logic [LFSR_W-1:0] s;
   logic [LFSR_W-1:0] mask;
   logic [4:0]        hi;
   logic [4:0]        tp;
   logic              fb;

   // Unrolled shift: fb = s[L-1] ^ s[T-1], shifted in at bit 0.
   always_comb begin
      mask     = lfsr_mask(poly);
      hi       = lfsr_len(poly) - 5'd1;
      tp       = lfsr_tap(poly) - 5'd1;
      s        = state_in & mask;
      bits_out = '0;
      fb       = 1'b0;
      for (int unsigned i = 0; i < DATA_W; i++) begin
         fb       = s[hi] ^ s[tp];
         s        = LFSR_W'({s, fb}) & mask;
         bits_out = DATA_W'({bits_out, fb});
      end
      state_out = s;
   end

endmodule

// File: rtl/prbs_gen.sv
// Link bring-up pattern source: a header of the seed word repeated n times,
// then a continuous PRBS7/15/23/31 stream, DATA_W bits per beat, valid/ready.
// Optional build macro PRBS_ERR_INJ_EN adds err_inj for single-bit error injection.
// Ports:
//  CLK, RST             : clock, synchronous active-high reset
//  start, stop          : run control pulses
//  n, seed, poly_sel    : header repeat count, seed/header word, polynomial (sampled at start)
//  out_data, out_valid  : output beat
//  out_ready            : sink accepts beat
//  busy                 : controller not idle
//  hdr_done             : pulse after the last header word is accepted
//  err_inj              : (PRBS_ERR_INJ_EN only) arm a single bit-0 error
import prbs_pkg::*;

module prbs_gen #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned SEED_W = 32,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              start,
   input  logic              stop,
   input  logic [CNT_W-1:0]  n,
   input  logic [SEED_W-1:0] seed,
   input  logic [1:0]        poly_sel,
`ifdef PRBS_ERR_INJ_EN
   input  logic              err_inj,
`endif
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              hdr_done
);

   localparam int unsigned NWORDS   = SEED_W / DATA_W;
   localparam int unsigned IDX_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

   state_t              state_q, state_d;
   logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [CNT_W-1:0]    rep_q, rep_d;
   logic [CNT_W-1:0]    n_q, n_d;
   logic [SEED_W-1:0]   seed_q, seed_d;
   poly_e               poly_q, poly_d;
   logic [DATA_W-1:0]   data_d;
   logic                valid_d;
   logic                busy_d;
   logic                hdr_done_d;
`ifdef PRBS_ERR_INJ_EN
   logic                err_q, err_d;
   logic                err_arm;
`endif

   logic                accept;
   poly_e               poly_in;
   logic [LFSR_W-1:0]   seed_slice;
   logic [LFSR_W-1:0]   load_state;
   logic [LFSR_W-1:0]   step_in;
   poly_e               step_poly;
   logic [LFSR_W-1:0]   step_state;
   logic [DATA_W-1:0]   step_bits;

   // Header word i of w, MSB-first.
   function automatic logic [DATA_W-1:0] hdr_word(input logic [SEED_W-1:0] w,
                                                  input logic [IDX_W-1:0]  i);
      return DATA_W'(w >> ((NWORDS - 1 - 32'(i)) * DATA_W));
   endfunction

   assign accept  = out_valid & out_ready;
   assign poly_in = poly_e'(poly_sel);

   // Seed load with lockup avoidance: an all-zero active slice becomes all ones.
   always_comb begin
      seed_slice = LFSR_W'(seed) & lfsr_mask(poly_in);
      load_state = (seed_slice == '0) ? lfsr_mask(poly_in) : seed_slice;
   end

   // In IDLE the step unit works on the seed being loaded, so the first PRBS
   // beat of an n=0 run is already scrambled.
   always_comb begin
      step_in   = (state_q == IDLE) ? load_state : lfsr_q;
      step_poly = (state_q == IDLE) ? poly_in    : poly_q;
   end

   prbs_lfsr_step #(
      .DATA_W (DATA_W)
   ) u_step (
      .state_in  (step_in),
      .poly      (step_poly),
      .state_out (step_state),
      .bits_out  (step_bits)
   );

   // Next-state and next-output logic.
   always_comb begin
      state_d    = state_q;
      lfsr_d     = lfsr_q;
      idx_d      = idx_q;
      rep_d      = rep_q;
      n_d        = n_q;
      seed_d     = seed_q;
      poly_d     = poly_q;
      data_d     = out_data;
      valid_d    = out_valid;
      hdr_done_d = 1'b0;
`ifdef PRBS_ERR_INJ_EN
      err_d      = err_q;
      err_arm    = 1'b0;
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               n_d     = n;
               seed_d  = seed;
               poly_d  = poly_in;
               idx_d   = '0;
               rep_d   = '0;
               valid_d = 1'b1;
               if (n != '0) begin
                  state_d = HEADER;
                  lfsr_d  = load_state;
                  data_d  = hdr_word(seed, '0);
               end else begin
                  state_d = PRBS;
                  lfsr_d  = step_state;
                  data_d  = step_bits;
               end
            end
         end

         HEADER: begin
            if (accept) begin
               if (idx_q == LAST_IDX && rep_q == (n_q - CNT_W'(1))) begin
                  state_d    = PRBS;
                  hdr_done_d = 1'b1;
                  lfsr_d     = step_state;
                  data_d     = step_bits;
               end else if (idx_q == LAST_IDX) begin
                  idx_d  = '0;
                  rep_d  = rep_q + CNT_W'(1);
                  data_d = hdr_word(seed_q, '0);
               end else begin
                  idx_d  = idx_q + IDX_W'(1);
                  data_d = hdr_word(seed_q, idx_q + IDX_W'(1));
               end
            end
         end

         PRBS: begin
`ifdef PRBS_ERR_INJ_EN
            err_arm = err_q | err_inj;
            err_d   = err_arm;
`endif
            if (accept) begin
               lfsr_d = step_state;
               data_d = step_bits;
`ifdef PRBS_ERR_INJ_EN
               // The error rides on the output word only; the LFSR is untouched.
               if (err_arm) begin
                  data_d[0] = ~step_bits[0];
                  err_d     = 1'b0;
               end
`endif
            end
         end

         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase

      // Abort: any in-flight beat is dropped, a beat accepted this cycle completes.
      if (stop && state_q != IDLE) begin
         state_d = IDLE;
         valid_d = 1'b0;
         data_d  = '0;
         idx_d   = '0;
         rep_d   = '0;
`ifdef PRBS_ERR_INJ_EN
         err_d   = 1'b0;
`endif
      end

      busy_d = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         lfsr_q    <= {LFSR_W{1'b1}};
         idx_q     <= '0;
         rep_q     <= '0;
         n_q       <= '0;
         seed_q    <= '0;
         poly_q    <= POLY7;
         out_data  <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         hdr_done  <= 1'b0;
`ifdef PRBS_ERR_INJ_EN
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         lfsr_q    <= lfsr_d;
         idx_q     <= idx_d;
         rep_q     <= rep_d;
         n_q       <= n_d;
         seed_q    <= seed_d;
         poly_q    <= poly_d;
         out_data  <= data_d;
         out_valid <= valid_d;
         busy      <= busy_d;
         hdr_done  <= hdr_done_d;
`ifdef PRBS_ERR_INJ_EN
         err_q     <= err_d;
`endif
      end
   end

endmodule
